// File: rtl/perm_lane_pkg.sv
// Shared constants and types for the permutation lane buffer.
// Optional err output is enabled by defining PERM_LANE_ERR_EN.
package perm_lane_pkg;

  localparam int LANE_W    = 64;
  localparam int LANES_DEF = 25;

  typedef enum logic {
    IN_IDLE,
    IN_FILL
  } in_st_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/perm_lane_store.sv
// Bank/lane flop array: one synchronous write port,
// one combinational read port, contents never reset.
module perm_lane_store
  import perm_lane_pkg::*;
#(
  parameter int W     = LANE_W,
  parameter int LANES = LANES_DEF,
  parameter int NBUF  = 2,
  parameter int BW    = 1,
  parameter int IW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [BW-1:0] wbank,
  input  logic [IW-1:0] widx,
  input  logic [W-1:0]  wdata,
  input  logic [BW-1:0] rbank,
  input  logic [IW-1:0] ridx,
  output logic [W-1:0]  rdata
);

  localparam int DEPTH = NBUF * LANES;
  localparam int AW    = clog2_min1(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;

  assign wa = AW'(wbank) * AW'(LANES) + AW'(widx);
  assign ra = AW'(rbank) * AW'(LANES) + AW'(ridx);

  // Write one lane into its bank slot.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wdata;
  end

  assign rdata = mem[ra];

endmodule

// File: rtl/perm_lane_buf.sv
// Store-and-forward lane block buffer feeding perm_blk.
// Define PERM_LANE_ERR_EN to add the err protocol pulse.
module perm_lane_buf
  import perm_lane_pkg::*;
#(
  parameter int W     = LANE_W,
  parameter int LANES = LANES_DEF,
  parameter int NBUF  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pushin,
  input  logic         firstin,
  input  logic [W-1:0] din,
  output logic         stopin,
  output logic         pushout,
  output logic         firstout,
  output logic [W-1:0] dout,
`ifdef PERM_LANE_ERR_EN
  output logic         err,
`endif
  input  logic         stopout
);

  localparam int BW = clog2_min1(NBUF);
  localparam int IW = clog2_min1(LANES);
  localparam int NW = $clog2(NBUF + 1);

  localparam logic [IW-1:0] LAST  = IW'(LANES - 1);
  localparam logic [BW-1:0] BLAST = BW'(NBUF - 1);
  localparam logic [NW-1:0] NMAX  = NW'(NBUF);

  in_st_t        st;
  logic [BW-1:0] wbank;
  logic [BW-1:0] rbank;
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;
  logic [IW-1:0] waddr;
  logic [NW-1:0] nfull;

  logic acc;
  logic we;
  logic wdone;
  logic xfer;
  logic rdone;

  assign acc   = pushin && !stopin;
  assign we    = acc && (firstin || st == IN_FILL);
  assign waddr = firstin ? '0 : widx;
  assign wdone = we && waddr == LAST;
  assign xfer  = pushout && !stopout;
  assign rdone = xfer && ridx == LAST;

  assign stopin   = nfull == NMAX;
  assign pushout  = nfull != '0;
  assign firstout = pushout && ridx == '0;

  // Input FSM: fill the write bank, restart on a new firstin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= IN_IDLE;
      wbank <= '0;
      widx  <= '0;
    end else if (we) begin
      if (wdone) begin
        st    <= IN_IDLE;
        widx  <= '0;
        wbank <= (wbank == BLAST) ? '0 : wbank + 1'b1;
      end else begin
        st   <= IN_FILL;
        widx <= waddr + 1'b1;
      end
    end
  end

  // Output pointers: walk lanes, then move to the next bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbank <= '0;
      ridx  <= '0;
    end else if (xfer) begin
      if (rdone) begin
        ridx  <= '0;
        rbank <= (rbank == BLAST) ? '0 : rbank + 1'b1;
      end else begin
        ridx <= ridx + 1'b1;
      end
    end
  end

  // Count of complete banks; fill and drain cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nfull <= '0;
    end else if (wdone && !rdone) begin
      nfull <= nfull + 1'b1;
    end else if (rdone && !wdone) begin
      nfull <= nfull - 1'b1;
    end
  end

`ifdef PERM_LANE_ERR_EN
  // Flag a stray lane while idle or a restart mid-block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= acc && ((st == IN_IDLE && !firstin)
                  || (st == IN_FILL && firstin));
    end
  end
`endif

  perm_lane_store #(
    .W     (W),
    .LANES (LANES),
    .NBUF  (NBUF),
    .BW    (BW),
    .IW    (IW)
  ) u_store (
    .clk   (clk),
    .we    (we),
    .wbank (wbank),
    .widx  (waddr),
    .wdata (din),
    .rbank (rbank),
    .ridx  (ridx),
    .rdata (dout)
  );

endmodule

// File: tb/tb_perm_lane_buf.sv
// Randomised bench for perm_lane_buf with a queue-based model.
// Define PERM_LANE_ERR_EN to also check the err pulse.
module tb_perm_lane_buf;

  localparam int L = 25;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pushin = 1'b0;
  logic        firstin = 1'b0;
  logic [63:0] din = '0;
  logic        stopin;
  logic        pushout;
  logic        firstout;
  logic [63:0] dout;
  logic        stopout;
  logic        err;

  logic        so_rand = 1'b0;
  logic        so_val = 1'b0;
  logic        rnd_bit = 1'b0;

  logic        s_push = 1'b0;
  logic        s_first = 1'b0;
  logic [7:0]  s_din = '0;
  logic        s_so = 1'b1;
  logic        s_stopin;
  logic        s_pushout;
  logic        s_firstout;
  logic [7:0]  s_dout;
  logic        s_err;

  int n_vec = 0;
  int n_fail = 0;

  assign stopout = so_rand ? rnd_bit : so_val;

  always #5 clk = ~clk;

  perm_lane_buf #(.W(64), .LANES(L), .NBUF(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .pushin   (pushin),
    .firstin  (firstin),
    .din      (din),
    .stopin   (stopin),
    .pushout  (pushout),
    .firstout (firstout),
    .dout     (dout),
`ifdef PERM_LANE_ERR_EN
    .err      (err),
`endif
    .stopout  (stopout)
  );

  perm_lane_buf #(.W(8), .LANES(4), .NBUF(1)) u_small (
    .clk      (clk),
    .reset    (reset),
    .pushin   (s_push),
    .firstin  (s_first),
    .din      (s_din),
    .stopin   (s_stopin),
    .pushout  (s_pushout),
    .firstout (s_firstout),
    .dout     (s_dout),
`ifdef PERM_LANE_ERR_EN
    .err      (s_err),
`endif
    .stopout  (s_so)
  );

`ifndef PERM_LANE_ERR_EN
  assign err = 1'b0;
  assign s_err = 1'b0;
`endif

  // ---------------- reference model ----------------
  logic [63:0] part[$];
  logic [63:0] fq[$];
  bit          in_fill = 0;
  bit          m_err = 0;

  function automatic int m_blocks();
    return (fq.size() + L - 1) / L;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        part.delete();
        fq.delete();
        in_fill = 0;
        m_err = 0;
      end else begin
        bit ms;
        bit acc;
        ms  = (m_blocks() == N);
        acc = pushin && !ms;
        if (fq.size() != 0 && !stopout)
          void'(fq.pop_front());
        m_err = acc && (firstin == in_fill);
        if (acc) begin
          if (firstin) begin
            part.delete();
            part.push_back(din);
            in_fill = 1;
          end else if (in_fill) begin
            part.push_back(din);
          end
          if (part.size() == L) begin
            foreach (part[i]) fq.push_back(part[i]);
            part.delete();
            in_fill = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        logic        ep;
        logic        es;
        logic        ef;
        logic [63:0] ed;
        bit          ok;
        ep = fq.size() != 0;
        es = m_blocks() == N;
        ef = ep && (fq.size() % L == 0);
        ed = ep ? fq[0] : 64'h0;
        ok = pushout == ep && stopin == es
          && firstout == ef && (!ep || dout == ed);
`ifdef PERM_LANE_ERR_EN
        ok = ok && err == m_err;
`endif
        n_vec++;
        if (!ok) begin
          n_fail++;
          $display("FAIL model t=%0t push=%b/%b stop=%b/%b first=%b/%b dout=%h/%h err=%b/%b",
                   $time, pushout, ep, stopin, es,
                   firstout, ef, dout, ed, err, m_err);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic lane(input logic f, input logic [63:0] d);
    int  n;
    bit  a;
    n = 0;
    pushin  = 1'b1;
    firstin = f;
    din     = d;
    do begin
      a = !stopin;
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!a && n < 300);
    pushin = 1'b0;
    if (!a) begin
      n_fail++;
      $display("FAIL lane_timeout din=%h", d);
    end
  endtask

  task automatic push_blk(input logic [63:0] base);
    for (int i = 0; i < L; i++)
      lane(i == 0, base + 64'(i));
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (fq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout left=%0d", fq.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_stopin", 64'(stopin), 64'd0);
    chk("rst_pushout", 64'(pushout), 64'd0);
    chk("rst_firstout", 64'(firstout), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Block A: latency and ordered drain.
    push_blk(64'd0);
    chk("a_push", 64'(pushout), 64'd1);
    chk("a_first", 64'(firstout), 64'd1);
    chk("a_d0", dout, 64'd0);
    for (int i = 1; i < L; i++) begin
      @(negedge clk);
      if (i == 24) chk("a_d24", dout, 64'd24);
    end
    @(negedge clk);
    chk("a_idle", 64'(pushout), 64'd0);

    // Back-pressure: A and B fill both banks.
    so_val = 1'b1;
    push_blk(64'd0);
    push_blk(64'h1000);
    chk("bp_stopin", 64'(stopin), 64'd1);
    pushin  = 1'b1;
    firstin = 1'b1;
    din     = 64'h2000;
    repeat (3) @(negedge clk);
    chk("bp_hold", dout, 64'd0);
    so_val = 1'b0;
    n = 0;
    while (stopin && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release", 64'(n), 64'd25);
    lane(1'b1, 64'h2000);
    for (int i = 1; i < L; i++)
      lane(1'b0, 64'h2000 + 64'(i));
    so_rand = 1'b1;
    wait_empty();
    so_rand = 1'b0;

    // Restart mid-block and stray lane in idle.
    for (int i = 0; i < 10; i++)
      lane(i == 0, 64'hd00 + 64'(i));
    lane(1'b1, 64'h100);
`ifdef PERM_LANE_ERR_EN
    chk("err_restart", 64'(err), 64'd1);
`endif
    for (int i = 1; i < L; i++)
      lane(1'b0, 64'h100 + 64'(i));
    chk("e_d0", dout, 64'h100);
    chk("e_first", 64'(firstout), 64'd1);
    lane(1'b0, 64'hdead);
`ifdef PERM_LANE_ERR_EN
    chk("err_idle", 64'(err), 64'd1);
`endif
    wait_empty();

    // Reset mid-fill with a block pending.
    so_val = 1'b1;
    push_blk(64'h3000);
    for (int i = 0; i <= 12; i++)
      lane(i == 0, 64'h4000 + 64'(i));
    #2 reset = 1'b1;
    #1;
    chk("rf_push", 64'(pushout), 64'd0);
    chk("rf_stop", 64'(stopin), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    so_val = 1'b0;
    push_blk(64'h5000);
    chk("rf_d0", dout, 64'h5000);
    wait_empty();

    // Reset mid-drain at lane 7.
    push_blk(64'd0);
    repeat (7) @(negedge clk);
    chk("rd_d7", dout, 64'd7);
    #2 reset = 1'b1;
    #1;
    chk("rd_push", 64'(pushout), 64'd0);
    chk("rd_first", 64'(firstout), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    push_blk(64'h6000);
    chk("rd_d0", dout, 64'h6000);
    wait_empty();

    // Random traffic with random back-pressure.
    so_rand = 1'b1;
    for (int b = 0; b < 30; b++) begin
      if ($urandom_range(0, 7) == 0)
        lane(1'b0, {$urandom, $urandom});
      if ($urandom_range(0, 5) == 0)
        for (int i = 0; i < 5; i++)
          lane(i == 0, {$urandom, $urandom});
      for (int i = 0; i < L; i++) begin
        if ($urandom_range(0, 3) == 0)
          @(negedge clk);
        lane(i == 0, {$urandom, $urandom});
      end
    end
    wait_empty();
    so_rand = 1'b0;

    // Single-bank instance: second block waits for drain.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      s_push  = 1'b1;
      s_first = (i == 0);
      s_din   = 8'(8'h11 + i);
      @(negedge clk);
    end
    s_push = 1'b0;
    chk("s_stop", 64'(s_stopin), 64'd1);
    chk("s_push", 64'(s_pushout), 64'd1);
    chk("s_d0", 64'(s_dout), 64'h11);
    chk("s_f0", 64'(s_firstout), 64'd1);
    s_push  = 1'b1;
    s_first = 1'b1;
    s_din   = 8'h21;
    repeat (3) @(negedge clk);
    chk("s_stall", 64'(s_stopin), 64'd1);
    chk("s_hold", 64'(s_dout), 64'h11);
    s_so = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("s_drain", 64'(s_dout), 64'(8'h11 + i));
    end
    @(negedge clk);
    chk("s_empty", 64'(s_pushout), 64'd0);
    chk("s_free", 64'(s_stopin), 64'd0);
    @(negedge clk);
    s_first = 1'b0;
    for (int i = 1; i < 4; i++) begin
      s_din = 8'(8'h21 + i);
      @(negedge clk);
    end
    s_push = 1'b0;
    chk("s2_f0", 64'(s_firstout), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("s2_d", 64'(s_dout), 64'(8'h21 + i));
      @(negedge clk);
    end
    chk("s2_empty", 64'(s_pushout), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/perm_lane_buf.md
Name: perm_lane_buf

Overview:
- Parametrised store-and-forward lane block buffer between the NOC interface (noc_intf) and the permutation core (perm_blk).
- Collects LANES lanes of W bits per block, delimited by firstin, into one of NBUF bank slots.
- Emits a block downstream only once it is complete, so the core can run on one state while the next state loads.
- Generalises the fixed 1600-bit, 25-lane, single-state path to any lane width, lane count and bank depth, and adds protocol-error recovery.

Parameters:
- W, 64, lane data width in bits.
- LANES, 25, lanes per block (25 gives a 5x5 state).
- NBUF, 2, number of block banks (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- pushin  in  1  producer lane valid.
- firstin  in  1  marks lane 0 of a block; meaningful only with pushin.
- din  in  W  producer lane data.
- stopin  out  1  back-pressure to producer; a lane is accepted only when pushin && !stopin.
- pushout  out  1  consumer lane valid.
- firstout  out  1  marks lane 0 of the outgoing block.
- dout  out  W  consumer lane data.
- stopout  in  1  consumer back-pressure; a transfer occurs when pushout && !stopout.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: stopin=0, pushout=0, firstout=0. dout is don't-care while pushout=0.
- Reset clears both FSMs, all pointers and nfull. Storage contents are not reset.
- Reset mid-block discards any partial input and any undrained blocks.
- Internal indices: wbank/rbank are max(1,$clog2(NBUF)) bits; widx/ridx are $clog2(LANES) bits; nfull (complete, undrained banks) is $clog2(NBUF+1) bits.
- Input FSM, IN_IDLE:
  - Accepted lane with firstin writes din to bank[wbank] lane 0, sets widx=1, moves to IN_FILL.
  - Accepted lane without firstin is discarded; state unchanged.
- Input FSM, IN_FILL:
  - Accepted lane without firstin writes lane widx, widx++.
  - When lane LANES-1 is written: nfull++, wbank wraps mod NBUF, widx=0, move to IN_IDLE.
  - Accepted lane with firstin restarts the current bank: writes lane 0, widx=1, state stays IN_FILL; the partial block is dropped.
- stopin = (nfull==NBUF), combinational from registers. The filling bank never counts as full, so stopin never asserts mid-block.
- Output path:
  - pushout = (nfull!=0); dout = bank[rbank][ridx], combinational read; firstout = pushout && ridx==0.
  - On a transfer, ridx++. On transferring lane LANES-1: ridx=0, rbank wraps mod NBUF, nfull--.
  - While stopout=1, pushout/firstout/dout hold stable.
- Simultaneous block completion (input) and block release (output) in one cycle: nfull unchanged, and stopin does not glitch.
- Latency: lane 0 appears on dout the cycle after the edge that writes input lane LANES-1, if the output side is idle.
- Throughput: one lane per cycle each side. With NBUF>=2, input and output overlap fully.
- NBUF=1 is legal: input stalls at IN_IDLE until the single bank has drained.

Optional Feature:
- Macro PERM_LANE_ERR_EN.
- Defined: adds output err (1 bit, reset 0), registered, pulsing for 1 cycle after either an accepted lane without firstin in IN_IDLE or an accepted firstin in IN_FILL.
- Undefined: no err port; the same discard/restart recovery happens silently.
- Datapath behaviour is identical either way.

Decomposition:
- Package perm_lane_pkg holds default constants LANE_W=64 and LANES_DEF=25, and typedef enum logic {IN_IDLE, IN_FILL} in_st_t.
- One sub-module, perm_lane_store: NBUF*LANES x W flop array with one synchronous write port (bank, idx, data, we) and one combinational read port (bank, idx). No reset on the array.

Test Plan:
- W=64, LANES=25, NBUF=2; push block A (din=lane index 0..24, firstin on lane 0) with stopout=0 -> pushout rises the cycle after lane 24 is written; dout=0..24 over 25 consecutive cycles; firstout only on 0; stopin stays 0.
- Push blocks A, B, C back-to-back with stopout=1 held -> stopin=1 from the cycle after B completes; C's lane 0 stalls. Release stopout -> A then B drain in order; stopin drops the cycle A's lane 24 transfers; C accepted unchanged.
- Toggle stopout randomly at 50% during a drain -> dout sequence 0..24 unbroken, with each value held while stopout=1.
- Push 10 lanes of block D, then firstin with a new block E (0x100..0x118) -> only E emitted; err pulses once (PERM_LANE_ERR_EN); a lane with no firstin in IN_IDLE -> dropped, err pulses.
- Assert reset mid-fill (lane 12) and mid-drain (ridx=7) -> outputs 0 asynchronously, nfull=0; next complete block emitted correctly from lane 0.
- NBUF=1, LANES=4, W=8 -> second block waits at stopin=1 until the first block's lane 3 transfers; no data corruption.
